// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input conditioner.
// Holds the FSM state encoding and the default parameter values.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        SETTLE_HI = 2'b01,
        STABLE_HI = 2'b10,
        SETTLE_LO = 2'b11
    } state_t;

    localparam int DEBOUNCE_SYNC_STAGES_DEF   = 2;
    localparam int DEBOUNCE_STABLE_CYCLES_DEF = 16;

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// The last flop of the cascade drives s.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEBOUNCE_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// Synchronising debouncer: qualifies a new level over STABLE_CYCLES cycles.
// Define DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic y,
    output logic rise,
    output logic fall,
    output logic settling
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .s    (s)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = SETTLE_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            SETTLE_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = SETTLE_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            SETTLE_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // y tracks the committed level, so it stays high while a fall is qualified.
    assign y_d = (state_d == STABLE_HI) || (state_d == SETTLE_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign y        = y_q;
    assign settling = (state_q == SETTLE_HI) || (state_q == SETTLE_LO);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = (state_q == SETTLE_HI) && (state_d == STABLE_HI);
        fall_d = (state_q == SETTLE_LO) && (state_d == STABLE_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with default parameters.
// Pulse expectations follow whether DEBOUNCE_EDGE_EN is defined.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic d;
    logic y;
    logic rise;
    logic fall;
    logic settling;

    int n_checks;
    int n_fail;

    debounce_sync dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .y       (y),
        .rise    (rise),
        .fall    (fall),
        .settling(settling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit do_reset;
        bit d;
        int n;
        bit y;
        bit settling;
        bit rise;
        bit fall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Asserts reset (checking outputs clear at once), holds two edges, then
    // releases just after an edge so the next edge is edge 1.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        d     = 1'b0;
        #1;
        check({tag, " reset y"}, y, 0);
        check({tag, " reset settling"}, settling, 0);
        check({tag, " reset rise"}, rise, 0);
        check({tag, " reset fall"}, fall, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   edge_no;
        int   rise_cnt;
        int   fall_cnt;
        int   rise_edge;
        int   first_y;
        int   burst_y;
        vec_t v;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        d        = 1'b0;

        // Clean rising step: settling for edges 3-17, y and rise on edge 18.
        vecs.push_back('{1, 1, 2,  0, 0, 0, 0});
        vecs.push_back('{0, 1, 15, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 1,  1, 0, 1, 0});
        vecs.push_back('{0, 1, 5,  1, 0, 0, 0});
        // Glitch: 10 cycles high is rejected, settling ends at edge 13.
        vecs.push_back('{1, 1, 2,  0, 0, 0, 0});
        vecs.push_back('{0, 1, 8,  0, 1, 0, 0});
        vecs.push_back('{0, 0, 2,  0, 1, 0, 0});
        vecs.push_back('{0, 0, 6,  0, 0, 0, 0});
        // Boundary: 16 cycles high is accepted, then falls 18 edges later.
        vecs.push_back('{1, 1, 2,  0, 0, 0, 0});
        vecs.push_back('{0, 1, 14, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1,  0, 1, 0, 0});
        vecs.push_back('{0, 0, 1,  1, 0, 1, 0});
        vecs.push_back('{0, 0, 15, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 1,  0, 0, 0, 1});
        vecs.push_back('{0, 0, 4,  0, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.do_reset) begin
                do_reset($sformatf("vec%0d", i));
            end
            d = v.d;
            for (int k = 0; k < v.n; k++) begin
                edge_step();
                check($sformatf("vec%0d.%0d y", i, k), y, v.y);
                check($sformatf("vec%0d.%0d settling", i, k), settling, v.settling);
                check($sformatf("vec%0d.%0d rise", i, k), rise, v.rise & EDGE_EN);
                check($sformatf("vec%0d.%0d fall", i, k), fall, v.fall & EDGE_EN);
            end
        end

        // Bounce burst: 3-cycle pulses for 60 cycles, then d settles high.
        do_reset("burst");
        rise_cnt = 0;
        fall_cnt = 0;
        burst_y  = 0;
        for (int i = 0; i < 20; i++) begin
            d = (i % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                edge_step();
                if (y) burst_y++;
                if (rise) rise_cnt++;
                if (fall) fall_cnt++;
            end
        end
        check("burst y during bounce", burst_y, 0);
        check("burst rise during bounce", rise_cnt, 0);
        d         = 1'b1;
        first_y   = 0;
        rise_edge = 0;
        for (int k = 1; k <= 30; k++) begin
            edge_step();
            if (y && first_y == 0) first_y = k;
            if (rise) begin
                rise_cnt++;
                rise_edge = k;
            end
            if (fall) fall_cnt++;
        end
        check("burst y edge after final toggle", first_y, 18);
        check("burst rise count", rise_cnt, EDGE_EN ? 1 : 0);
        check("burst rise edge", rise_edge, EDGE_EN ? 18 : 0);
        check("burst fall count", fall_cnt, 0);

        // Reset mid-settle: reset at edge 10 discards the qualification.
        do_reset("midsettle");
        d = 1'b1;
        for (edge_no = 1; edge_no <= 10; edge_no++) edge_step();
        check("midsettle settling before reset", settling, 1);
        rst_n = 1'b0;
        #1;
        check("midsettle async y", y, 0);
        check("midsettle async settling", settling, 0);
        check("midsettle async rise", rise, 0);
        check("midsettle async fall", fall, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rise_cnt = 0;
        first_y  = 0;
        for (int k = 1; k <= 25; k++) begin
            edge_step();
            if (y && first_y == 0) first_y = k;
            if (rise) begin
                rise_cnt++;
                check($sformatf("midsettle rise edge %0d", k), k, 18);
            end
        end
        check("midsettle y edge after release", first_y, 18);
        check("midsettle rise count", rise_cnt, EDGE_EN ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_debounce_sync
